// File: rtl/psum_deskew_collector_pkg.sv
// Shared sizing, lane types and the partial-sum widening helper for the
// systolic-array output collector.
package psum_deskew_collector_pkg;

  localparam int N          = 4;
  localparam int LOG_N      = 2;
  localparam int PSUM_W     = 16;
  localparam int ACC_W      = 32;
  localparam int FIFO_DEPTH = 2 * N;

  typedef logic signed [PSUM_W-1:0] psum_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  function automatic acc_t sext_psum(input psum_t p);
    return {{(ACC_W - PSUM_W){p[PSUM_W-1]}}, p};
  endfunction

endpackage

// File: rtl/psum_deskew_collector_col_fifo.sv
// Per-column synchronous FIFO; a push into a full FIFO is accepted only when
// a pop frees the head slot at the same edge.
module psum_deskew_collector_col_fifo
  import psum_deskew_collector_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int W     = ACC_W
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         do_push_s, do_pop_s;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_pop_s  = pop_i & ~empty_o;
    do_push_s = push_i & (~full_o | do_pop_s);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_d = wr_ptr_q + (AW + 1)'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + (AW + 1)'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push_s && !clr_i) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/psum_deskew_collector.sv
// Re-aligns skewed per-column partial sums into complete rows for writeback,
// counts rows per tile and flags dropped column samples.
module psum_deskew_collector
  import psum_deskew_collector_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [PSUM_W-1:0] psum_i [N],
  input  logic [N-1:0]      acc_valid_i,
  input  logic              clear_i,
  output logic [ACC_W-1:0]  row_o [N],
  output logic              row_valid_o,
  input  logic              row_ready_i,
  output logic              tile_done_o,
  output logic [LOG_N:0]    row_count_o,
  output logic              overflow_o
);

  logic [N-1:0]     fifo_full_s, fifo_empty_s, push_s, drop_s;
  logic [ACC_W-1:0] fifo_head_s [N];
  logic [ACC_W-1:0] psum_ext_s  [N];
  logic             row_avail_s, load_s, pop_s, xfer_s;

  logic [ACC_W-1:0] row_q [N], row_d [N];
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic [LOG_N:0]   count_q, count_d;

  // All columns pop together; clear_i suppresses every push and pop.
  always_comb begin
    row_avail_s = ~|fifo_empty_s;
    load_s      = row_avail_s & (~valid_q | row_ready_i);
    pop_s       = load_s & ~clear_i;
    xfer_s      = valid_q & row_ready_i;
    for (int j = 0; j < N; j++) begin
      psum_ext_s[j] = sext_psum(psum_i[j]);
      push_s[j]     = acc_valid_i[j] & (~fifo_full_s[j] | pop_s) & ~clear_i;
      drop_s[j]     = acc_valid_i[j] & fifo_full_s[j] & ~pop_s;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_col
    psum_deskew_collector_col_fifo #(
      .DEPTH(FIFO_DEPTH),
      .W    (ACC_W)
    ) u_fifo (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (clear_i),
      .push_i (push_s[g]),
      .pop_i  (pop_s),
      .din_i  (psum_ext_s[g]),
      .dout_o (fifo_head_s[g]),
      .full_o (fifo_full_s[g]),
      .empty_o(fifo_empty_s[g])
    );
  end

  always_comb begin
    row_d   = row_q;
    valid_d = valid_q;
    count_d = count_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    if (clear_i) begin
      row_d   = '{default: '0};
      valid_d = 1'b0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      if (load_s) begin
        row_d   = fifo_head_s;
        valid_d = 1'b1;
      end else if (row_ready_i) begin
        valid_d = 1'b0;
      end else begin
        valid_d = valid_q;
      end
      if (xfer_s) begin
        if (count_q == (LOG_N + 1)'(N - 1)) begin
          count_d = '0;
          done_d  = 1'b1;
        end else begin
          count_d = count_q + (LOG_N + 1)'(1);
        end
      end else begin
        count_d = count_q;
      end
      if (|drop_s) begin
        ovf_d = 1'b1;
      end else begin
        ovf_d = ovf_q;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_q   <= '{default: '0};
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      count_q <= '0;
    end else begin
      row_q   <= row_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
    end
  end

  assign row_o       = row_q;
  assign row_valid_o = valid_q;
  assign tile_done_o = done_q;
  assign row_count_o = count_q;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_psum_deskew_collector.sv
// Directed scenarios plus randomized traffic against a queue-based model of
// the collector's row alignment, handshake, tile counting and drop flag.
module tb_psum_deskew_collector;
  import psum_deskew_collector_pkg::*;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [PSUM_W-1:0] psum_i [N];
  logic [N-1:0]      acc_valid_i;
  logic              clear_i;
  logic [ACC_W-1:0]  row_o [N];
  logic              row_valid_o;
  logic              row_ready_i;
  logic              tile_done_o;
  logic [LOG_N:0]    row_count_o;
  logic              overflow_o;

  psum_deskew_collector dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .psum_i     (psum_i),
    .acc_valid_i(acc_valid_i),
    .clear_i    (clear_i),
    .row_o      (row_o),
    .row_valid_o(row_valid_o),
    .row_ready_i(row_ready_i),
    .tile_done_o(tile_done_o),
    .row_count_o(row_count_o),
    .overflow_o (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  logic [N*ACC_W-1:0] row_flat;
  always_comb begin
    for (int j = 0; j < N; j++) row_flat[j*ACC_W +: ACC_W] = row_o[j];
  end

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: per-column sample queues plus the presented row.
  logic [ACC_W-1:0]   mbuf [N][1024];
  int                 mhead [N];
  int                 mtail [N];
  logic               m_valid, m_done, m_ovf;
  logic [N*ACC_W-1:0] m_row;
  int                 m_count;

  function automatic logic [ACC_W-1:0] widen(input logic [PSUM_W-1:0] p);
    int v;
    v = int'($signed(p));
    return ACC_W'(v);
  endfunction

  task automatic model_reset();
    for (int j = 0; j < N; j++) begin
      mhead[j] = 0;
      mtail[j] = 0;
    end
    m_valid = 1'b0; m_done = 1'b0; m_ovf = 1'b0; m_row = '0; m_count = 0;
  endtask

  task automatic model_edge();
    bit xfer, avail;
    if (clear_i) begin
      model_reset();
    end else begin
      xfer   = m_valid && row_ready_i;
      m_done = 1'b0;
      if (xfer) begin
        m_count++;
        if (m_count == N) begin
          m_count = 0;
          m_done  = 1'b1;
        end
      end
      avail = 1'b1;
      for (int j = 0; j < N; j++) if (mtail[j] == mhead[j]) avail = 1'b0;
      if (avail && (!m_valid || row_ready_i)) begin
        for (int j = 0; j < N; j++) begin
          m_row[j*ACC_W +: ACC_W] = mbuf[j][mhead[j]];
          mhead[j]++;
        end
        m_valid = 1'b1;
      end else if (row_ready_i) begin
        m_valid = 1'b0;
      end
      for (int j = 0; j < N; j++) begin
        if (acc_valid_i[j]) begin
          if (mtail[j] - mhead[j] < FIFO_DEPTH) begin
            mbuf[j][mtail[j]] = widen(psum_i[j]);
            mtail[j]++;
          end else begin
            m_ovf = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    acc_valid_i = '0;
    clear_i     = 1'b0;
    for (int j = 0; j < N; j++) psum_i[j] = '0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    idle_inputs();
    row_ready_i = 1'b1;
    model_reset();
    @(posedge clk_i);
    #2 rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_skew(input int c);
    for (int j = 0; j < N; j++) begin
      acc_valid_i[j] = (c >= j) && (c <= j + 3);
      psum_i[j]      = acc_valid_i[j] ? PSUM_W'(10 * j + c - j) : '0;
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    idle_inputs();
    row_ready_i = 1'b1;
    #3;
    n_checks++;
    if ({row_valid_o, tile_done_o, overflow_o, row_count_o} !== '0)
      $display("FAIL reset_status got %b exp 0", {row_valid_o, tile_done_o, overflow_o, row_count_o});
    else n_pass++;
    n_checks++;
    if (row_flat !== '0) $display("FAIL reset_row got %h exp 0", row_flat);
    else n_pass++;
    do_reset();
  endtask

  task automatic test_aligned();
    logic [N*ACC_W-1:0] exp_row;
    do_reset();
    exp_row = {32'd4, 32'd3, 32'd2, 32'd1};
    acc_valid_i = 4'hF;
    for (int j = 0; j < N; j++) psum_i[j] = PSUM_W'(j + 1);
    tick();
    idle_inputs();
    n_checks++;
    if (row_valid_o !== 1'b0) $display("FAIL aligned_early got %b exp 0", row_valid_o);
    else n_pass++;
    tick();
    n_checks++;
    if (row_valid_o !== 1'b1 || row_flat !== exp_row)
      $display("FAIL aligned_row got %b/%h exp 1/%h", row_valid_o, row_flat, exp_row);
    else n_pass++;
    tick();
    n_checks++;
    if ({row_valid_o, tile_done_o, row_count_o} !== {1'b0, 1'b0, 3'd1})
      $display("FAIL aligned_after got v%b d%b c%0d exp v0 d0 c1", row_valid_o, tile_done_o, row_count_o);
    else n_pass++;
  endtask

  task automatic test_skew();
    logic [N*ACC_W-1:0] exp_row;
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      drive_skew(c);
      tick();
      n_checks++;
      if (row_valid_o !== ((c >= 4) && (c <= 7)))
        $display("FAIL skew_valid c%0d got %b", c, row_valid_o);
      else n_pass++;
      if (c >= 4 && c <= 7) begin
        for (int j = 0; j < N; j++) exp_row[j*ACC_W +: ACC_W] = ACC_W'(10 * j + c - 4);
        n_checks++;
        if (row_flat !== exp_row) $display("FAIL skew_row c%0d got %h exp %h", c, row_flat, exp_row);
        else n_pass++;
      end
      n_checks++;
      if ({tile_done_o, row_count_o} !== {c == 8, (c >= 5 && c <= 7) ? 3'(c - 4) : 3'd0})
        $display("FAIL skew_count c%0d got d%b c%0d", c, tile_done_o, row_count_o);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic [N*ACC_W-1:0] exp_row;
    int r;
    do_reset();
    for (int c = 0; c <= 14; c++) begin
      drive_skew(c);
      row_ready_i = !(c >= 5 && c <= 9);
      tick();
      r = (c <= 9) ? 0 : c - 9;
      n_checks++;
      if (row_valid_o !== ((c >= 4) && (c <= 12)) || overflow_o !== 1'b0)
        $display("FAIL bp_valid c%0d got v%b o%b", c, row_valid_o, overflow_o);
      else n_pass++;
      if (c >= 4 && c <= 12) begin
        for (int j = 0; j < N; j++) exp_row[j*ACC_W +: ACC_W] = ACC_W'(10 * j + r);
        n_checks++;
        if (row_flat !== exp_row) $display("FAIL bp_row c%0d got %h exp %h", c, row_flat, exp_row);
        else n_pass++;
      end
      n_checks++;
      if ({tile_done_o, row_count_o} !== {c == 13, (c >= 10 && c <= 12) ? 3'(c - 9) : 3'd0})
        $display("FAIL bp_count c%0d got d%b c%0d", c, tile_done_o, row_count_o);
      else n_pass++;
    end
    row_ready_i = 1'b1;
  endtask

  task automatic test_sign_overflow();
    logic [N*ACC_W-1:0] exp_row;
    do_reset();
    acc_valid_i = 4'hF;
    psum_i[0] = 16'hFFFF; psum_i[1] = 16'h8000; psum_i[2] = 16'h7FFF; psum_i[3] = 16'h0000;
    tick();
    idle_inputs();
    tick();
    exp_row = {32'h0000_0000, 32'h0000_7FFF, 32'hFFFF_8000, 32'hFFFF_FFFF};
    n_checks++;
    if (row_flat !== exp_row) $display("FAIL sext_row got %h exp %h", row_flat, exp_row);
    else n_pass++;
    tick();
    for (int k = 0; k <= 8; k++) begin
      acc_valid_i = 4'b0010;
      psum_i[1]   = PSUM_W'(100 + k);
      tick();
      n_checks++;
      if (overflow_o !== (k == 8)) $display("FAIL ovf_fill k%0d got %b exp %b", k, overflow_o, k == 8);
      else n_pass++;
    end
    idle_inputs();
    for (int k = 0; k <= 10; k++) begin
      acc_valid_i = (k < 8) ? 4'b1101 : 4'b0000;
      for (int j = 0; j < N; j++) if (j != 1) psum_i[j] = PSUM_W'(200 + 10 * j + k);
      tick();
      n_checks++;
      if (row_valid_o !== (k >= 1 && k <= 8) || overflow_o !== 1'b1)
        $display("FAIL ovf_drain_valid k%0d got v%b o%b", k, row_valid_o, overflow_o);
      else n_pass++;
      if (k >= 1 && k <= 8) begin
        for (int j = 0; j < N; j++)
          exp_row[j*ACC_W +: ACC_W] = (j == 1) ? ACC_W'(100 + k - 1) : ACC_W'(200 + 10 * j + k - 1);
        n_checks++;
        if (row_flat !== exp_row) $display("FAIL ovf_drain_row k%0d got %h exp %h", k, row_flat, exp_row);
        else n_pass++;
      end
    end
    idle_inputs();
  endtask

  task automatic test_clear();
    logic [N*ACC_W-1:0] exp_row;
    do_reset();
    for (int k = 0; k <= 8; k++) begin
      acc_valid_i = 4'b0001;
      psum_i[0]   = PSUM_W'(k + 1);
      tick();
    end
    idle_inputs();
    n_checks++;
    if (overflow_o !== 1'b1) $display("FAIL clr_ovf_set got %b exp 1", overflow_o);
    else n_pass++;
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    n_checks++;
    if ({overflow_o, row_valid_o} !== 2'b00) $display("FAIL clr_ovf_clear got %b exp 00", {overflow_o, row_valid_o});
    else n_pass++;
    for (int c = 0; c <= 4; c++) begin
      acc_valid_i = (c < 2) ? 4'hF : 4'b0001;
      for (int j = 0; j < N; j++) psum_i[j] = PSUM_W'(50 + 10 * c + j);
      tick();
      if (c == 1) begin
        exp_row = {32'd53, 32'd52, 32'd51, 32'd50};
        n_checks++;
        if (row_flat !== exp_row || row_valid_o !== 1'b1)
          $display("FAIL clr_pre_row got %b/%h exp 1/%h", row_valid_o, row_flat, exp_row);
        else n_pass++;
      end
    end
    n_checks++;
    if ({row_valid_o, row_count_o} !== {1'b0, 3'd2}) $display("FAIL clr_pre_count got %b exp 0010", {row_valid_o, row_count_o});
    else n_pass++;
    clear_i = 1'b1;
    acc_valid_i = 4'b0001;
    psum_i[0] = 16'd99;
    tick();
    idle_inputs();
    n_checks++;
    if ({row_valid_o, tile_done_o, overflow_o, row_count_o} !== '0)
      $display("FAIL clr_state got %b exp 0", {row_valid_o, tile_done_o, overflow_o, row_count_o});
    else n_pass++;
    tick();
    n_checks++;
    if ({row_valid_o, tile_done_o} !== 2'b00) $display("FAIL clr_idle got %b exp 00", {row_valid_o, tile_done_o});
    else n_pass++;
    acc_valid_i = 4'hF;
    for (int j = 0; j < N; j++) psum_i[j] = PSUM_W'(5 + j);
    tick();
    idle_inputs();
    tick();
    exp_row = {32'd8, 32'd7, 32'd6, 32'd5};
    n_checks++;
    if (row_flat !== exp_row || row_valid_o !== 1'b1)
      $display("FAIL clr_post_row got %b/%h exp 1/%h", row_valid_o, row_flat, exp_row);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    row_ready_i = 1'b0;
    acc_valid_i = 4'hF;
    for (int j = 0; j < N; j++) psum_i[j] = PSUM_W'(j + 1);
    tick();
    tick();
    idle_inputs();
    n_checks++;
    if (row_valid_o !== 1'b1) $display("FAIL arst_pre got %b exp 1", row_valid_o);
    else n_pass++;
    #2 rst_ni = 1'b0;
    #1;
    n_checks++;
    if (row_valid_o !== 1'b0 || row_flat !== '0)
      $display("FAIL arst_immediate got %b/%h exp 0/0", row_valid_o, row_flat);
    else n_pass++;
    model_reset();
    #2 rst_ni = 1'b1;
    row_ready_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++;
      if ({row_valid_o, row_count_o} !== '0) $display("FAIL arst_idle c%0d got %b exp 0", c, {row_valid_o, row_count_o});
      else n_pass++;
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int j = 0; j < N; j++) begin
        acc_valid_i[j] = ($urandom_range(0, 3) != 0);
        psum_i[j]      = PSUM_W'($urandom());
      end
      row_ready_i = ($urandom_range(0, 3) != 0);
      clear_i     = ($urandom_range(0, 79) == 0);
      tick();
      n_checks++;
      if ({row_valid_o, tile_done_o, overflow_o, row_count_o} !== {m_valid, m_done, m_ovf, 3'(m_count)})
        $display("FAIL rand_status cyc%0d got %b exp %b", cyc,
                 {row_valid_o, tile_done_o, overflow_o, row_count_o}, {m_valid, m_done, m_ovf, 3'(m_count)});
      else n_pass++;
      if (m_valid) begin
        n_checks++;
        if (row_flat !== m_row) $display("FAIL rand_row cyc%0d got %h exp %h", cyc, row_flat, m_row);
        else n_pass++;
      end
    end
    idle_inputs();
    row_ready_i = 1'b1;
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_skew();
    test_backpressure();
    test_sign_overflow();
    test_clear();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/psum_deskew_collector.md
Name: psum_deskew_collector

Overview:
- Sits directly downstream of the systolic array controller and the bottom PE row.
- Captures the skewed per-column partial sums that leave the array, gated by the controller's per-column accumulator-valid strobes.
- Buffers each column independently, re-aligns the columns into complete output rows and hands each row to the writeback stage over a valid/ready handshake.
- Counts rows and flags the end of each N-row result tile.

Parameters:
- PSUM_W, 16, width of one PE partial sum at the array output (signed).
- ACC_W, 32, width of each output lane; PSUM_W ≤ ACC_W.
- FIFO_DEPTH, 2*N, entries per column FIFO; must be a power of two and ≥ N.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- psum_i [N]  in  PSUM_W each  bottom-row PE outputs, column j on psum_i[j].
- acc_valid_i [N]  in  1 each  column j result valid this cycle (from controller acc_valid_o).
- clear_i  in  1  synchronous flush of all buffered state.
- row_o [N]  out  ACC_W each  aligned output row, lane j = column j.
- row_valid_o  out  1  row_o holds a valid row.
- row_ready_i  in  1  downstream accepts row_o.
- tile_done_o  out  1  single-cycle pulse when the N-th row of a tile is accepted.
- row_count_o  out  LOG_N+1  rows accepted in the current tile.
- overflow_o  out  1  sticky: a column sample was dropped.

Behaviour:
- Reset (rst_ni low, asynchronous) clears all outputs and state immediately:
  - row_o = 0, row_valid_o = 0, tile_done_o = 0, row_count_o = 0, overflow_o = 0.
  - All FIFOs empty; read/write pointers 0.
- Reset may assert mid-tile; any buffered data is lost. No partial row is emitted after rst_ni rises.
- Push, per column j each cycle:
  - If acc_valid_i[j] and (FIFO j not full, or FIFO j pops this cycle), write sign-extend(psum_i[j]) to ACC_W.
  - If acc_valid_i[j] and FIFO j is full with no pop this cycle, drop the sample and set overflow_o. overflow_o holds until reset or clear_i.
- Row available: asserted when every column FIFO is non-empty (count computed after the previous edge).
- Pop and load:
  - Load condition: row available and (row_valid_o = 0 or row_ready_i = 1).
  - When the load condition holds, all N FIFOs pop together at the same edge. row_o is loaded with the N head entries and row_valid_o = 1.
  - When the load condition does not hold and row_ready_i = 1, row_valid_o goes to 0.
- Handshake:
  - A transfer occurs when row_valid_o and row_ready_i are both high.
  - row_o and row_valid_o must not change while row_valid_o = 1 and row_ready_i = 0.
  - Back-to-back rows are supported at one row per cycle.
- Latency: the last column sample of a row is sampled at edge E. row_valid_o is high after edge E+1, provided row_ready_i was high or row_valid_o was 0.
- Skew tolerance: column j may lead column k by up to FIFO_DEPTH−1 samples without loss. Ordering within a column is FIFO; row r of the output contains the r-th sample of every column.
- Row counter:
  - Increments on each transfer.
  - On the transfer that takes it to N, row_count_o wraps to 0 and tile_done_o pulses high for exactly one cycle (the cycle after that edge).
- clear_i (synchronous):
  - At the next edge, empties all FIFOs and sets row_valid_o = 0, row_count_o = 0, overflow_o = 0.
  - Overrides any push, pop or transfer in the same cycle; tile_done_o is not pulsed.
- Simultaneous events:
  - Push and pop on the same FIFO in one cycle leaves its count unchanged.
  - A transfer and a new load in the same cycle present the next row without a bubble.

Decomposition:
- Shared package additions: PSUM_W and ACC_W constants, plus a psum_t/acc_t typedef pair. N and LOG_N already exist there.
- One sub-module, col_fifo: a synchronous FIFO (depth FIFO_DEPTH, width ACC_W) with push, pop, full, empty and a dout port. It uses the same asynchronous active-low reset and is instantiated N times.
- Deskew, row register, counter and overflow logic live in the top module.

Test Plan (N=4, PSUM_W=16, ACC_W=32, FIFO_DEPTH=8):
- Aligned input:
  - Stimulus: at one edge, all acc_valid_i high with psum_i = {1,2,3,4}; row_ready_i = 1.
  - Expect: row_valid_o high two edges later with row_o = {1,2,3,4}, asserted for one cycle, and row_count_o = 1.
- Classic skew:
  - Stimulus: column j is valid at cycles j..j+3 with values 10*j+r for r = 0..3; row_ready_i = 1.
  - Expect: rows {0,10,20,30}, {1,11,21,31}, {2,12,22,32}, {3,13,23,33} on consecutive cycles.
  - Expect: tile_done_o pulses once after the 4th transfer and row_count_o returns to 0.
- Backpressure:
  - Stimulus: same traffic as classic skew, with row_ready_i = 0 for 5 cycles after the first row_valid_o.
  - Expect: row_o holds stable at {0,10,20,30}; no data is lost, overflow_o stays 0, and all 4 rows are delivered in order once row_ready_i = 1.
- Sign extension and overflow:
  - Stimulus: psum_i[0] = 16'hFFFF. Separately, fill column 1 with 9 samples while column 2 sends none.
  - Expect: lane 0 of row_o = 32'hFFFF_FFFF. overflow_o rises on the 9th sample of column 1 and the dropped value never appears on row_o.
- clear_i mid-tile:
  - Stimulus: after 2 rows accepted and 3 samples buffered in column 0, pulse clear_i together with acc_valid_i[0].
  - Expect: row_count_o = 0, row_valid_o = 0, overflow_o = 0, all FIFOs empty, and no tile_done_o pulse.
- Async reset:
  - Stimulus: drop rst_ni between clock edges while row_valid_o = 1.
  - Expect: row_valid_o and row_o go to 0 before the next edge, and the output stays idle after rst_ni is released with no stale row emitted.
